multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle control unit with a state machine that time-shares one memory port and one ALU across instruction phases. Each phase is gated by a memory-ready handshake. It drives the PC, IR, register-file, ALU-mux and memory strobes, and reports per-instruction completion and illegal-opcode events.

## Interface
Parameters:
- none. Opcode, state and select encodings live in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the IR
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each legal instruction
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state (debug)

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
  - Codes 12–15 are unused and return to FETCH.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - While mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
  - While mem_ready=0: stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Opcode is sampled only here.
  - lw/sw → MEMADR; R → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
  - Any other opcode → FETCH, with illegal_op=1 for that cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1, then go to FETCH.
- MEMWR: iord=1, mem_write=1. Stay until mem_ready; in the ready cycle assert instr_done and go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1, then go to FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1, then go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1, then go to FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on the rising edge of clk. reset_n asynchronously forces state=FETCH.
- Outputs are combinational from state and mem_ready (Mealy only on the handshake-gated strobes).
- While reset_n=0, every output including mem_read is forced to 0 and state reads 0.
  - After reset deasserts, the first FETCH request appears in the same cycle.
- Minimum latency with mem_ready tied to 1:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Illegal opcode costs 2 cycles (FETCH, DECODE) and produces no instr_done.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction abandons it: no partial strobes after reset_n falls, and no instr_done.
- Exactly one instr_done per legal instruction. It never coincides with illegal_op.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - the 4-bit state encoding;
  - ALU_OP_ADD/SUB/FUNCT;
  - SRCB_* and PCSRC_* select codes.
- One sub-module, mc_output_decode: purely combinational, (state, mem_ready) → control outputs.
- The state register and next-state logic stay in multicycle_control.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 → all outputs 0, state=0. Release → mem_read=1 and iord=0 in the first cycle.
- lw with mem_ready=1 → states 0,1,2,3,4 over 5 cycles. In state 4: reg_write=1, mem_to_reg=1, instr_done=1.
- lw with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles, total 8 cycles; reg_write absent until MEMWB.
- Sequence R-type, beq, j, addi with mem_ready=1 → 4, 3, 3, 4 cycles; instr_done count 4.
  - beq cycle shows pc_write_cond=1, alu_op=01, pc_source=01.
  - j cycle shows pc_write=1, pc_source=10.
- opcode=111111 → DECODE pulses illegal_op=1, returns to FETCH next cycle, instr_done stays 0.
- reset_n dropped in MEMWR while mem_ready=0 → mem_write falls immediately; state=0 after release; no instr_done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Opcodes, the state code, datapath select codes and the control bundle all live here.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-strobe decode from the current phase and the memory handshake.
// Only the FETCH/MEMWR strobes depend on mem_ready; illegal_op is produced by the top.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord       = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REGB;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: phase register, next-phase logic and reset gating of strobes.
// state | meaning
// 0 FETCH  | read instruction at PC, PC+4 (waits on mem_ready)
// 1 DECODE | branch target into ALUOut, dispatch on opcode
// 2 MEMADR | effective address for lw/sw
// 3 MEMRD  | data read at ALUOut (waits on mem_ready)
// 4 MEMWB  | MDR into rt
// 5 MEMWR  | data write at ALUOut (waits on mem_ready)
// 6 EXEC   | R-type ALU operation
// 7 ALUWB  | ALUOut into rd
// 8 BRANCH | beq compare and conditional PC load
// 9 JUMP   | PC <- jump target
// 10 ADDIEX| regA + imm
// 11 ADDIWB| ALUOut into rt
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   is_store_q, is_store_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // The lw/sw decision is latched in DECODE so the opcode is not needed afterwards.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_store_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (dec_ctrl)
    );

    // Reset must silence everything immediately, including the FETCH read request.
    always_comb begin
        ctrl            = dec_ctrl;
        ctrl.illegal_op = (state_q == S_DECODE) && !is_legal_op(opcode);
        if (!reset_n) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table of per-instruction latencies,
// a phase-list reference model under random mem_ready, and directed reset corner cases.
module tb_multicycle_control;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    outs_t act;
    always_comb begin
        act               = '0;
        act.pc_write      = pc_write;
        act.pc_write_cond = pc_write_cond;
        act.iord          = iord;
        act.mem_read      = mem_read;
        act.mem_write     = mem_write;
        act.ir_write      = ir_write;
        act.reg_dst       = reg_dst;
        act.mem_to_reg    = mem_to_reg;
        act.reg_write     = reg_write;
        act.alu_src_a     = alu_src_a;
        act.alu_src_b     = alu_src_b;
        act.alu_op        = alu_op;
        act.pc_source     = pc_source;
        act.instr_done    = instr_done;
        act.illegal_op    = illegal_op;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s actual=%0h expected=%0h", name, a, e);
        else passed++;
    endtask

    function automatic logic legal(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    endfunction

    // Expected strobes for each phase, read straight from the phase descriptions.
    function automatic outs_t exp_out(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        outs_t o;
        o = '0;
        case (st)
            4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_write = rdy; o.ir_write = rdy; end
            4'd1:  begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op); end
            4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd3:  begin o.iord = 1; o.mem_read = 1; end
            4'd4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
            4'd5:  begin o.iord = 1; o.mem_write = 1; o.instr_done = rdy; end
            4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd7:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
            4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
                         o.pc_write_cond = 1; o.instr_done = 1; end
            4'd9:  begin o.pc_source = 2'b10; o.pc_write = 1; o.instr_done = 1; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd11: begin o.reg_write = 1; o.instr_done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    logic [3:0] exp_q[$];

    task automatic build_path(input logic [5:0] op);
        exp_q = {};
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        case (op)
            6'b100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
            6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
            6'b000000: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
            6'b000100: exp_q.push_back(4'd8);
            6'b000010: exp_q.push_back(4'd9);
            6'b001000: begin exp_q.push_back(4'd10); exp_q.push_back(4'd11); end
            default: ;
        endcase
    endtask

    int exp_done = 0, exp_ill = 0, got_done = 0, got_ill = 0;

    // One instruction against the phase-list model; entered and left at posedge+1 in FETCH.
    task automatic model_instr(input logic [5:0] op, input bit rand_rdy);
        logic [3:0] st;
        logic       rdy;
        outs_t      e;
        opcode = op;
        build_path(op);
        if (legal(op)) exp_done++;
        else exp_ill++;
        while (exp_q.size() > 0) begin
            st  = exp_q[0];
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_ready = rdy;
            @(negedge clk);
            e = exp_out(st, rdy, op);
            check("model_state", 32'(state), 32'(st));
            check("model_outs", 32'(act), 32'(e));
            got_done += int'(instr_done);
            got_ill  += int'(illegal_op);
            if (!((st == 4'd0 || st == 4'd3 || st == 4'd5) && !rdy)) void'(exp_q.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         fwait;
        int         mwait;
        int         cycles;
        int         done;
        int         ill;
    } vec_t;

    // Runs one instruction with mem_ready low for the given number of FETCH / MEMRD-MEMWR cycles.
    task automatic run_vec(input vec_t v, input int idx);
        int  cycles, fw, mw, done, ill;
        bit  seen_dec, fin;
        logic rdy;
        logic [3:0] cur;
        cycles = 0; fw = 0; mw = 0; done = 0; ill = 0; seen_dec = 0; fin = 0;
        opcode = v.op;
        for (int n = 0; n < 60 && !fin; n++) begin
            cur = state;
            if (seen_dec && cur == 4'd0) begin
                fin = 1;
            end else begin
                if (cur == 4'd1) seen_dec = 1;
                if (cur == 4'd0)                     rdy = (fw >= v.fwait);
                else if (cur == 4'd3 || cur == 4'd5) rdy = (mw >= v.mwait);
                else                                 rdy = 1'($urandom_range(0, 1));
                if (!rdy && cur == 4'd0) fw++;
                if (!rdy && (cur == 4'd3 || cur == 4'd5)) mw++;
                mem_ready = rdy;
                @(negedge clk);
                cycles++;
                done += int'(instr_done);
                ill  += int'(illegal_op);
                @(posedge clk);
                #1;
            end
        end
        if (!fin) $display("FAIL vec%0d_timeout actual=%0d expected=%0d", idx, cycles, v.cycles);
        check($sformatf("vec%0d_finished", idx), 32'(fin), 32'd1);
        check($sformatf("vec%0d_cycles", idx), 32'(cycles), 32'(v.cycles));
        check($sformatf("vec%0d_done", idx), 32'(done), 32'(v.done));
        check($sformatf("vec%0d_illegal", idx), 32'(ill), 32'(v.ill));
    endtask

    vec_t vecs[12];

    initial begin
        logic [5:0] op;
        int         k, dir_done;

        vecs[0]  = '{6'b100011, 0, 0, 5, 1, 0};
        vecs[1]  = '{6'b100011, 0, 3, 8, 1, 0};
        vecs[2]  = '{6'b101011, 0, 0, 4, 1, 0};
        vecs[3]  = '{6'b101011, 2, 1, 7, 1, 0};
        vecs[4]  = '{6'b000000, 0, 0, 4, 1, 0};
        vecs[5]  = '{6'b000100, 0, 0, 3, 1, 0};
        vecs[6]  = '{6'b000010, 0, 0, 3, 1, 0};
        vecs[7]  = '{6'b001000, 0, 0, 4, 1, 0};
        vecs[8]  = '{6'b111111, 0, 0, 2, 0, 1};
        vecs[9]  = '{6'b111111, 1, 0, 3, 0, 1};
        vecs[10] = '{6'b000001, 0, 0, 2, 0, 1};
        vecs[11] = '{6'b000100, 2, 0, 5, 1, 0};

        // Reset held with mem_ready high: everything silent.
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 32'(act), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        #2 reset_n = 1'b1;
        #1;
        check("release_mem_read", 32'(mem_read), 32'd1);
        check("release_iord", 32'(iord), 32'd0);
        check("release_state", 32'(state), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // lw with mem_ready tied high, then R, beq, j, addi under the phase model.
        model_instr(6'b100011, 1'b0);
        dir_done = got_done;
        model_instr(6'b000000, 1'b0);
        model_instr(6'b000100, 1'b0);
        model_instr(6'b000010, 1'b0);
        model_instr(6'b001000, 1'b0);
        check("seq_done_count", 32'(got_done - dir_done), 32'd4);
        model_instr(6'b111111, 1'b0);

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            model_instr(op, 1'b1);
        end
        check("total_done", 32'(got_done), 32'(exp_done));
        check("total_illegal", 32'(got_ill), 32'(exp_ill));

        // sw abandoned by reset while stalled in MEMWR.
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("memwr_state", 32'(state), 32'd5);
        check("memwr_write", 32'(mem_write), 32'd1);
        check("memwr_no_done", 32'(instr_done), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_outs", 32'(act), 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("abort_hold_outs", 32'(act), 32'd0);
        #2 reset_n = 1'b1;
        #1;
        check("abort_release_state", 32'(state), 32'd0);
        check("abort_release_done", 32'(instr_done), 32'd0);
        check("abort_release_read", 32'(mem_read), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
